puf_challenge_gen: RTL and testbench

- Upstream stage of pufInputNetwork. Generates a sequence of pseudo-random PUF challenges from a seeded Galois LFSR.
- Each challenge is held stable for a programmable settle time, then presented to the response-capture side with a valid/ready handshake.
- chal_out feeds pufInputNetwork.dataIn directly. The network output drives the PDL challenge lines.

---
 rtl/puf_chal_pkg.sv | 18 +
 rtl/puf_lfsr.sv | 36 +++
 rtl/puf_challenge_gen.sv | 132 +++++++++++++
 tb/tb_puf_challenge_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_chal_pkg.sv
// Shared types and LFSR helpers for the PUF challenge generator.
package puf_chal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT,
    DONE
  } state_e;

  // x^32 + x^22 + x^2 + x + 1 in Galois (right-shift) form
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  function automatic logic [31:0] lfsr_step32(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Parameterised Galois LFSR with synchronous load, step enable and zero-seed guard.
module puf_lfsr
  import puf_chal_pkg::*;
#(
  parameter int unsigned      Width = 32,
  parameter logic [Width-1:0] Taps  = Width'(TAPS_32)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] seed,
  input  logic             step,
  output logic [Width-1:0] state
);

  logic [Width-1:0] next_state;

  generate
    if (Width == 32) begin : g_pkg_step
      assign next_state = lfsr_step32(state, Taps);
    end else begin : g_generic_step
      assign next_state = (state >> 1) ^ (state[0] ? Taps : '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Width'(1);
    end else if (load) begin
      state <= (seed == '0) ? Width'(1) : seed;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/puf_challenge_gen.sv
// PUF challenge sequencer: LFSR challenges, settle delay, valid/ready handoff.
// Optional true/complement issue of each state: define PUF_CHAL_COMPLEMENT_EN.
module puf_challenge_gen
  import puf_chal_pkg::*;
#(
  parameter int unsigned      Width        = 32,
  parameter int unsigned      CountW       = 16,
  parameter int unsigned      SettleCycles = 8,
  parameter logic [Width-1:0] Taps         = Width'(TAPS_32)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [Width-1:0]  seed,
  input  logic              start,
  input  logic [CountW-1:0] num_challenges,
  input  logic              chal_ready,
  output logic [Width-1:0]  chal_out,
  output logic              chal_valid,
  output logic              busy,
  output logic              done,
  output logic [CountW-1:0] issued_count
);

  localparam int unsigned    SW            = $clog2(SettleCycles + 1);
  localparam logic [SW-1:0]  SETTLE_RELOAD = SW'(SettleCycles - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q;
  logic [CountW-1:0] target_q, issued_q, issued_inc;
  logic              valid_q, done_q;
  logic [Width-1:0]  lfsr_state;
  logic              lfsr_load, lfsr_step;
  logic              hs, last, step_ok;

  assign hs         = (state_q == PRESENT) && valid_q && chal_ready;
  assign issued_inc = issued_q + CountW'(1);
  assign last       = (issued_inc == target_q);

  puf_lfsr #(
    .Width (Width),
    .Taps  (Taps)
  ) u_lfsr (
    .clk   (clk),
    .rst   (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

`ifdef PUF_CHAL_COMPLEMENT_EN
  logic phase_q;

  // Advance only after the complement issue, or when an odd run ends on a true issue
  assign step_ok  = phase_q || last;
  assign chal_out = phase_q ? ~lfsr_state : lfsr_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else if (hs) begin
      phase_q <= !step_ok;
    end
  end
`else
  assign step_ok  = 1'b1;
  assign chal_out = lfsr_state;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_load = seed_load;
        if (start) state_d = (num_challenges != '0) ? SETTLE : DONE;
      end
      SETTLE:  if (settle_q == '0) state_d = PRESENT;
      PRESENT: begin
        if (hs) begin
          lfsr_step = step_ok;
          state_d   = last ? DONE : SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // chal_valid is registered, so it rises one cycle after PRESENT is entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      target_q <= '0;
      issued_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q <= num_challenges;
            issued_q <= '0;
            settle_q <= SETTLE_RELOAD;
          end
        end
        SETTLE: if (settle_q != '0) settle_q <= settle_q - SW'(1);
        PRESENT: begin
          if (hs) begin
            issued_q <= issued_inc;
            settle_q <= SETTLE_RELOAD;
            valid_q  <= 1'b0;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign chal_valid   = valid_q;
  assign done         = done_q;
  assign busy         = (state_q == SETTLE) || (state_q == PRESENT);
  assign issued_count = issued_q;

endmodule

// File: tb/tb_puf_challenge_gen.sv
// Self-checking bench for puf_challenge_gen: timeline model plus directed literal vectors.
`timescale 1ns/1ps
module tb_puf_challenge_gen;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SC = 8;
  localparam logic [31:0] TP = 32'h80200003;

  logic          clk = 1'b0, rst = 1'b0;
  logic          seed_load = 1'b0, start = 1'b0, chal_ready = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [CW-1:0] num_challenges = '0;
  logic [W-1:0]  chal_out;
  logic          chal_valid, busy, done;
  logic [CW-1:0] issued_count;

  always #5 clk = ~clk;

  puf_challenge_gen #(
    .Width        (W),
    .CountW       (CW),
    .SettleCycles (SC),
    .Taps         (TP)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .seed_load      (seed_load),
    .seed           (seed),
    .start          (start),
    .num_challenges (num_challenges),
    .chal_ready     (chal_ready),
    .chal_out       (chal_out),
    .chal_valid     (chal_valid),
    .busy           (busy),
    .done           (done),
    .issued_count   (issued_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiply-by-x over GF(2) modulo the feedback polynomial, right-shift form
  function automatic logic [31:0] spec_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TP) : (s >> 1);
  endfunction

  // Timeline model: counts edges to the next offer instead of tracking FSM states
  logic [31:0] m_lfsr = 32'h1;
  bit          m_ph = 0, m_idle = 1, m_busy = 0, m_valid = 0, m_done = 0, m_finish = 0;
  int          m_cd = 0;
  logic [15:0] m_issued = '0, m_target = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 32'h1; m_ph = 0; m_idle = 1; m_busy = 0; m_valid = 0;
      m_done = 0; m_finish = 0; m_cd = 0; m_issued = '0; m_target = '0;
    end else begin
      m_done = 0;
      if (m_finish) begin
        m_done = 1; m_finish = 0; m_idle = 1;
      end else if (m_idle) begin
        if (seed_load) m_lfsr = (seed == '0) ? 32'h1 : seed;
        if (start) begin
          m_issued = '0;
          m_target = num_challenges;
          m_idle   = 0;
          if (num_challenges == '0) m_finish = 1;
          else begin m_busy = 1; m_cd = SC + 1; end
        end
      end else if (m_busy) begin
        if (m_valid && chal_ready) begin
          m_valid  = 0;
          m_issued = m_issued + 16'd1;
`ifdef PUF_CHAL_COMPLEMENT_EN
          if (m_ph || m_issued == m_target) begin m_lfsr = spec_step(m_lfsr); m_ph = 0; end
          else m_ph = 1;
`else
          m_lfsr = spec_step(m_lfsr);
`endif
          if (m_issued == m_target) begin m_busy = 0; m_finish = 1; end
          else m_cd = SC + 1;
        end else if (!m_valid) begin
          m_cd--;
          if (m_cd == 0) m_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("chal_out", chal_out, m_ph ? ~m_lfsr : m_lfsr);
      check("chal_valid", chal_valid, m_valid);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("issued_count", issued_count, m_issued);
    end
  end

  logic [31:0] cap[$];
  int done_cnt = 0;
  always @(posedge clk) if (!rst && chal_valid && chal_ready) cap.push_back(chal_out);
  always @(negedge clk) if (chk_en && done) done_cnt++;

  function automatic logic [31:0] capv(input int i);
    return (i < cap.size()) ? cap[i] : 32'hxxxxxxxx;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_seed(input logic [31:0] s);
    seed_load = 1'b1; seed = s; tick(); seed_load = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_challenges = n; tick(); start = 1'b0; num_challenges = 16'hFFFF;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin tick(); n++; end
    check({name, "_done_seen"}, done, 1'b1);
    tick();
  endtask

  logic [31:0] exp4 [4];
  logic [31:0] v;
  int n, d0;

  initial begin
`ifdef PUF_CHAL_COMPLEMENT_EN
    exp4 = '{32'h00000001, 32'hFFFFFFFE, 32'h80200003, 32'h7FDFFFFC};
`else
    exp4 = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
`endif
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_chal_out", chal_out, 32'h1);
    check("rst_valid", chal_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_issued", issued_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Seed 1, three challenges, always ready
    chal_ready = 1'b1;
    do_seed(32'h1);
    cap.delete(); d0 = done_cnt;
    start = 1'b1; num_challenges = 16'd3; tick(); start = 1'b0;
    n = 0;
    while (!chal_valid && n < 30) begin tick(); n++; end
    check("valid_latency", n, 9);
    wait_done("seq");
    tick();
    check("seq_count", cap.size(), 3);
    for (int i = 0; i < 3; i++) check("seq_value", capv(i), exp4[i]);
    check("seq_done_pulses", done_cnt - d0, 1);
    check("seq_issued", issued_count, 16'd3);

    // Zero seed maps to 1
    do_seed(32'h0);
    cap.delete();
    do_start(16'd1);
    wait_done("zseed");
    check("zseed_value", capv(0), 32'h1);

    // Backpressure holds the offer
    chal_ready = 1'b0;
    do_seed(32'h12345678);
    cap.delete();
    do_start(16'd2);
    n = 0;
    while (!chal_valid && n < 30) begin tick(); n++; end
    check("bp_valid_seen", chal_valid, 1'b1);
    v = chal_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", chal_valid, 1'b1);
      check("bp_hold_out", chal_out, v);
    end
    check("bp_no_hs", cap.size(), 0);
    chal_ready = 1'b1;
    tick();
    check("bp_hs", cap.size(), 1);
    check("bp_value", capv(0), 32'h12345678);
    wait_done("bp");

    // Zero-length run
    d0 = done_cnt;
    start = 1'b1; num_challenges = 16'd0; tick(); start = 1'b0;
    check("zero_done_e0", done, 1'b0);
    tick();
    check("zero_done_e1", done, 1'b1);
    tick();
    check("zero_done_e2", done, 1'b0);
    check("zero_issued", issued_count, 16'd0);
    repeat (3) tick();
    check("zero_pulses", done_cnt - d0, 1);

    // start/seed_load while busy are ignored
    do_seed(32'h1);
    cap.delete();
    do_start(16'd3);
    repeat (4) tick();
    seed_load = 1'b1; seed = 32'hDEADBEEF; start = 1'b1; num_challenges = 16'd5;
    tick();
    seed_load = 1'b0; start = 1'b0;
    wait_done("busy_ign");
    check("busy_ign_count", cap.size(), 3);
    for (int i = 0; i < 3; i++) check("busy_ign_value", capv(i), exp4[i]);

    // Reset during settle of the second challenge
    do_seed(32'h1);
    cap.delete();
    do_start(16'd3);
    n = 0;
    while (cap.size() < 1 && n < 30) begin tick(); n++; end
    check("mid_first_hs", cap.size(), 1);
    repeat (3) tick();
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", chal_out, 32'h1);
    check("mid_rst_valid", chal_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_issued", issued_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) tick();
    check("mid_no_done", done_cnt - d0, 0);

    // Four-challenge run from seed 1
    do_seed(32'h1);
    cap.delete();
    do_start(16'd4);
    wait_done("four");
    check("four_count", cap.size(), 4);
    for (int i = 0; i < 4; i++) check("four_value", capv(i), exp4[i]);
    check("four_issued", issued_count, 16'd4);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
